// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types used by the pmem responder slice.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_mem_data;

  // Byte offset within a 16-byte line; these address bits never select a line.
  localparam int unsigned LineOffsetW = 4;
  typedef logic [LineOffsetW-1:0] lc3b_line_offset;

  // Latched request type.
  typedef enum logic {READ, WRITE} pmem_op_t;

endpackage

// File: rtl/pmem_array.sv
// Line storage: LINES x 128-bit, one synchronous read/write port.
module pmem_array
  import lc3b_types::*;
#(
  parameter int unsigned LINES = 64,
  parameter int unsigned IdxW  = $clog2(LINES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IdxW-1:0]    index,
  input  logic               we,
  input  lc3b_mem_data       wdata,
  output lc3b_mem_data       rdata
);

  lc3b_mem_data mem [LINES];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
  end

  // Registered read every cycle; only the value captured on entry to a read RESP matters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Line-granular physical-memory responder with fixed response latency and
// a sticky flag for requesters that break the hold-until-resp handshake.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LINES   = 64,
  parameter int unsigned LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  lc3b_word     pmem_address,
  input  lc3b_mem_data pmem_wdata,
  output logic         pmem_resp,
  output lc3b_mem_data pmem_rdata,
  output logic         proto_err
);

  localparam int unsigned IdxW    = $clog2(LINES);
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  pmem_op_t        op_q;
  logic [IdxW-1:0] idx_q;
  lc3b_mem_data    wdata_q;
  logic            resp_q;
  logic            err_q;

  logic            req_any;
  pmem_op_t        req_op;
  logic [IdxW-1:0] req_idx;
  logic            req_viol;
  logic [IdxW-1:0] arr_idx;
  logic            arr_we;
  lc3b_mem_data    arr_rdata;

  // Offset bits and aliased upper bits play no part in line selection.
  logic unused_addr;
  assign unused_addr = ^{pmem_address[15:LineOffsetW+IdxW], pmem_address[LineOffsetW-1:0]};

  // Decode the incoming request; write wins when both lines are high.
  always_comb begin
    req_any  = pmem_read | pmem_write;
    req_op   = pmem_write ? WRITE : READ;
    req_idx  = pmem_address[LineOffsetW +: IdxW];
    req_viol = !req_any || (req_op != op_q) || (req_idx != idx_q);
  end

  // In IDLE the array reads the incoming index so LATENCY==1 still gets a registered read.
  always_comb begin
    arr_idx = (state_q == StIdle) ? req_idx : idx_q;
    arr_we  = (state_q == StResp) && (op_q == WRITE) && !rst;
  end

  // Request FSM, latches, latency counter and protocol-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= READ;
      idx_q   <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            op_q    <= req_op;
            idx_q   <= req_idx;
            wdata_q <= pmem_wdata;
            cnt_q   <= CntLoad;
            if (pmem_read && pmem_write) begin
              err_q <= 1'b1;
            end
            if (LATENCY == 1) begin
              state_q <= StResp;
              resp_q  <= 1'b1;
            end else begin
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (req_viol) begin
            err_q <= 1'b1;
          end
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
            resp_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= 4'(cnt_q - 4'd1);
          end
        end
        StResp: begin
          if (req_viol) begin
            err_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pmem_array #(
    .LINES (LINES),
    .IdxW  (IdxW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .index (arr_idx),
    .we    (arr_we),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Reset in the RESP cycle suppresses the pulse as well as the write.
  assign pmem_resp  = resp_q && !rst;
  assign pmem_rdata = arr_rdata;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: three instances (LATENCY 4, 1, 15) with a shadow
// memory model and a queue of expected read lines.
module tb_pmem_responder;
  import lc3b_types::*;

  logic         clk = 1'b0;
  logic         rst;
  lc3b_word     addr;
  lc3b_mem_data wdata;
  logic         rd    [3];
  logic         wr    [3];
  logic         resp  [3];
  lc3b_mem_data rdata [3];
  logic         perr  [3];

  int unsigned  cyc = 0;
  int           nchk = 0;
  int           nerr = 0;

  lc3b_mem_data mem_m [3][64];
  lc3b_mem_data exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmem_responder #(.LINES(64), .LATENCY(4)) u_dut (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]), .pmem_address(addr),
    .pmem_wdata(wdata), .pmem_resp(resp[0]), .pmem_rdata(rdata[0]), .proto_err(perr[0])
  );

  pmem_responder #(.LINES(64), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]), .pmem_address(addr),
    .pmem_wdata(wdata), .pmem_resp(resp[1]), .pmem_rdata(rdata[1]), .proto_err(perr[1])
  );

  pmem_responder #(.LINES(64), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .pmem_read(rd[2]), .pmem_write(wr[2]), .pmem_address(addr),
    .pmem_wdata(wdata), .pmem_resp(resp[2]), .pmem_rdata(rdata[2]), .proto_err(perr[2])
  );

  // Drive a request and update the model / push the expected read line.
  task automatic drive(input int inst, input bit r, input bit w, input lc3b_word a,
                       input lc3b_mem_data d);
    addr      = a;
    wdata     = d;
    rd[inst]  = r;
    wr[inst]  = w;
    if (w) mem_m[inst][a[9:4]] = d;
    else if (r) exp_q.push_back(mem_m[inst][a[9:4]]);
  endtask

  // Wait (bounded) for resp; check arrival cycle and, for reads, the line.
  task automatic wait_resp(input int inst, input int lat, input string name, input bit is_rd);
    int           n = 0;
    bit           got = 0;
    lc3b_mem_data exp;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (resp[inst] === 1'b1) got = 1;
    end
    nchk++;
    if (!got || n != lat) begin
      nerr++;
      $display("FAIL %s latency: got %0d cycles (resp seen=%0b), expected %0d", name, n, got, lat);
    end
    if (is_rd) begin
      exp = exp_q.pop_front();
      nchk++;
      if (rdata[inst] !== exp) begin
        nerr++;
        $display("FAIL %s rdata: got %h, expected %h", name, rdata[inst], exp);
      end
    end
  endtask

  task automatic release_req(input int inst);
    @(posedge clk); #1;
    rd[inst] = 1'b0;
    wr[inst] = 1'b0;
  endtask

  task automatic run_txn(input int inst, input bit r, input bit w, input lc3b_word a,
                         input lc3b_mem_data d, input int lat, input string name);
    drive(inst, r, w, a, d);
    wait_resp(inst, lat, name, r && !w);
    release_req(inst);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (resp[i] !== 1'b0 || perr[i] !== 1'b0 || rdata[i] !== '0) begin
        nerr++;
        $display("FAIL reset inst%0d: resp=%b perr=%b rdata=%h, expected 0/0/0",
                 i, resp[i], perr[i], rdata[i]);
      end
    end
  endtask

  task automatic test_basic();
    run_txn(0, 0, 1, 16'h0120, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 4, "basic_wr");
    run_txn(0, 1, 0, 16'h012E, '0, 4, "basic_rd");
    nchk++;
    if (perr[0] !== 1'b0) begin
      nerr++;
      $display("FAIL basic proto_err: got %b, expected 0", perr[0]);
    end
  endtask

  task automatic test_latency();
    run_txn(1, 0, 1, 16'h0010, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1, "lat1_wr");
    run_txn(1, 1, 0, 16'h0010, '0, 1, "lat1_rd");
    run_txn(2, 0, 1, 16'h0010, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 15, "lat15_wr");
    run_txn(2, 1, 0, 16'h0010, '0, 15, "lat15_rd");
  endtask

  task automatic test_alias();
    run_txn(0, 0, 1, 16'h0040, 128'h0BADF00D_12345678_9ABCDEF0_0F1E2D3C, 4, "alias_wr");
    run_txn(0, 1, 0, 16'h0440, '0, 4, "alias_rd");
  endtask

  task automatic test_back_to_back();
    int unsigned t0;
    run_txn(0, 0, 1, 16'h0300, 128'hFEEDFACE_00000300_C0FFEE00_00000003, 4, "b2b_prefill");
    t0 = cyc;
    drive(0, 0, 1, 16'h0200, 128'h00000200_11111111_22222222_33333333);
    wait_resp(0, 4, "b2b_wr", 1'b0);
    @(posedge clk); #1;
    wr[0] = 1'b0;
    drive(0, 1, 0, 16'h0300, '0);
    nchk++;
    if (cyc - t0 != 5) begin
      nerr++;
      $display("FAIL b2b second accept: got t+%0d, expected t+5", cyc - t0);
    end
    wait_resp(0, 4, "b2b_rd", 1'b1);
    nchk++;
    if (cyc - t0 != 9) begin
      nerr++;
      $display("FAIL b2b resp time: got t+%0d, expected t+9", cyc - t0);
    end
    nchk++;
    if (perr[0] !== 1'b0) begin
      nerr++;
      $display("FAIL b2b proto_err: got %b, expected 0", perr[0]);
    end
    release_req(0);
    run_txn(0, 1, 0, 16'h0200, '0, 4, "b2b_rd_back");
  endtask

  task automatic test_both_high();
    drive(0, 1, 1, 16'h0500, 128'h50505050_A5A5A5A5_12121212_EFEFEFEF);
    wait_resp(0, 4, "both_wr", 1'b0);
    release_req(0);
    nchk++;
    if (perr[0] !== 1'b1) begin
      nerr++;
      $display("FAIL both proto_err: got %b, expected 1", perr[0]);
    end
    apply_reset();
    run_txn(0, 1, 0, 16'h0500, '0, 4, "both_rd");
  endtask

  task automatic test_drop();
    int n = 0;
    drive(0, 0, 1, 16'h0600, 128'h66666666_77777777_88888888_99999999);
    repeat (2) begin
      @(posedge clk); #1;
      n++;
    end
    nchk++;
    if (perr[0] !== 1'b0) begin
      nerr++;
      $display("FAIL drop pre proto_err: got %b, expected 0", perr[0]);
    end
    wr[0] = 1'b0;
    while (resp[0] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    nchk++;
    if (n != 4) begin
      nerr++;
      $display("FAIL drop latency: got %0d cycles, expected 4", n);
    end
    repeat (5) @(posedge clk);
    #1;
    nchk++;
    if (perr[0] !== 1'b1) begin
      nerr++;
      $display("FAIL drop sticky proto_err: got %b, expected 1", perr[0]);
    end
    apply_reset();
    nchk++;
    if (perr[0] !== 1'b0) begin
      nerr++;
      $display("FAIL drop cleared proto_err: got %b, expected 0", perr[0]);
    end
    run_txn(0, 1, 0, 16'h0600, '0, 4, "drop_rd");
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    run_txn(0, 0, 1, 16'h0700, {4{32'hAAAAAAAA}}, 4, "abort_prefill");
    // Aborted write goes straight to the pins so the model keeps the old line.
    addr  = 16'h0700;
    wdata = {4{32'h55555555}};
    wr[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b1;
    wr[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      if (resp[0] === 1'b1) seen++;
      @(posedge clk); #1;
    end
    nchk++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL abort resp count: got %0d, expected 0", seen);
    end
    run_txn(0, 1, 0, 16'h0700, '0, 4, "abort_rd");
  endtask

  initial begin
    rst   = 1'b1;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_latency();
    test_alias();
    test_back_to_back();
    test_both_high();
    test_drop();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
